// File: rtl/rom_dp_lookup.sv
// rom_dp_lookup: request/response front end for a two-port lookup ROM with a
// fixed read latency. Two independent lanes (A -> ROM port A, B -> ROM port B).
// Each lane takes valid/ready address requests carrying a tag and returns
// {data, tag} in acceptance order on a valid/ready output. The ROM cannot stall,
// so each request holds a credit for an output FIFO slot from acceptance until pop.
//
// Ports (per lane x in {a, b}):
//   clk, rst                 single clock, synchronous active-high reset
//   x_in_valid/ready         request handshake
//   x_in_addr, x_in_tag      request address and opaque tag
//   x_out_valid/ready        response handshake (FIFO head, first-word-fall-through)
//   x_out_data, x_out_tag    ROM word and the tag of the request that fetched it
//   rom_addra/b              ROM address, combinational copy of x_in_addr
//   rom_douta/b              ROM read data, valid ROM_LATENCY edges after the address

// One lane: valid/tag pipeline alongside the ROM, then an output FIFO.
module rom_dp_lane #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 9,
    parameter int unsigned TAG_W       = 8,
    parameter int unsigned ROM_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [ADDR_W-1:0] i_in_addr,
    input  logic [TAG_W-1:0]  i_in_tag,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [TAG_W-1:0]  o_out_tag,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_dout
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + ROM_LATENCY + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned ENT_W = DATA_W + TAG_W;

    logic [ROM_LATENCY-1:0] r_vld;
    logic [TAG_W-1:0]       r_tag [ROM_LATENCY];
    logic [ENT_W-1:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    logic [CNT_W-1:0]       w_inflight;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_out_valid;
    logic [ENT_W-1:0]       w_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Requests currently inside the ROM pipeline.
    always_comb begin
        w_inflight = '0;
        for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
            w_inflight = w_inflight + CNT_W'(r_vld[i]);
        end
    end

    // Credit check: a same-cycle pop is deliberately not counted.
    assign w_ready     = !rst && ((r_count + w_inflight) < CNT_W'(FIFO_DEPTH));
    assign w_accept    = i_in_valid && w_ready;
    assign w_push      = !rst && r_vld[ROM_LATENCY-1];
    assign w_out_valid = !rst && (r_count != '0);
    assign w_pop       = w_out_valid && i_out_ready;
    assign w_head      = r_mem[r_rd_ptr];

    assign o_in_ready  = w_ready;
    assign o_out_valid = w_out_valid;
    assign o_out_data  = w_head[ENT_W-1:TAG_W];
    assign o_out_tag   = w_head[TAG_W-1:0];
    assign o_rom_addr  = i_in_addr;

    // Valid/tag pipeline tracking the ROM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_accept;
            r_tag[0] <= i_in_tag;
            for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // FIFO storage, no reset needed: entries are only read when counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_rom_dout, r_tag[ROM_LATENCY-1]};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Credits reserve a slot for every in-flight request, so a push never meets a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))));
        end
    end
endmodule

// Top: two independent lanes, each bound to one ROM port.
module rom_dp_lookup #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 9,
    parameter int unsigned TAG_W       = 8,
    parameter int unsigned ROM_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_in_valid,
    output logic              a_in_ready,
    input  logic [ADDR_W-1:0] a_in_addr,
    input  logic [TAG_W-1:0]  a_in_tag,
    output logic              a_out_valid,
    input  logic              a_out_ready,
    output logic [DATA_W-1:0] a_out_data,
    output logic [TAG_W-1:0]  a_out_tag,
    input  logic              b_in_valid,
    output logic              b_in_ready,
    input  logic [ADDR_W-1:0] b_in_addr,
    input  logic [TAG_W-1:0]  b_in_tag,
    output logic              b_out_valid,
    input  logic              b_out_ready,
    output logic [DATA_W-1:0] b_out_data,
    output logic [TAG_W-1:0]  b_out_tag,
    output logic [ADDR_W-1:0] rom_addra,
    output logic [ADDR_W-1:0] rom_addrb,
    input  logic [DATA_W-1:0] rom_douta,
    input  logic [DATA_W-1:0] rom_doutb
);
    rom_dp_lane #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
        .ROM_LATENCY(ROM_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_lane_a (
        .clk        (clk),
        .rst        (rst),
        .i_in_valid (a_in_valid),
        .o_in_ready (a_in_ready),
        .i_in_addr  (a_in_addr),
        .i_in_tag   (a_in_tag),
        .o_out_valid(a_out_valid),
        .i_out_ready(a_out_ready),
        .o_out_data (a_out_data),
        .o_out_tag  (a_out_tag),
        .o_rom_addr (rom_addra),
        .i_rom_dout (rom_douta)
    );

    rom_dp_lane #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
        .ROM_LATENCY(ROM_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_lane_b (
        .clk        (clk),
        .rst        (rst),
        .i_in_valid (b_in_valid),
        .o_in_ready (b_in_ready),
        .i_in_addr  (b_in_addr),
        .i_in_tag   (b_in_tag),
        .o_out_valid(b_out_valid),
        .i_out_ready(b_out_ready),
        .o_out_data (b_out_data),
        .o_out_tag  (b_out_tag),
        .o_rom_addr (rom_addrb),
        .i_rom_dout (rom_doutb)
    );
endmodule

// File: tb/tb_rom_dp_lookup.sv
// Testbench for rom_dp_lookup: two-cycle ROM model with rom[i] = i[8:0] ^ 9'h155,
// per-lane scoreboards filled on accepted requests and drained on popped responses.
module tb_rom_dp_lookup;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 9;
    localparam int unsigned TAG_W  = 8;

    logic              clk;
    logic              rst;
    logic              a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [ADDR_W-1:0] a_in_addr;
    logic [TAG_W-1:0]  a_in_tag, a_out_tag;
    logic [DATA_W-1:0] a_out_data;
    logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [ADDR_W-1:0] b_in_addr;
    logic [TAG_W-1:0]  b_in_tag, b_out_tag;
    logic [DATA_W-1:0] b_out_data;
    logic [ADDR_W-1:0] rom_addra, rom_addrb;
    logic [DATA_W-1:0] rom_douta, rom_doutb;
    logic [DATA_W-1:0] rom_a1, rom_b1;

    int n_checks = 0;
    int n_fail   = 0;
    int resp_a   = 0;
    int resp_b   = 0;
    logic [DATA_W+TAG_W-1:0] q_a[$];
    logic [DATA_W+TAG_W-1:0] q_b[$];
    logic [DATA_W+TAG_W-1:0] exp_a, exp_b;

    rom_dp_lookup dut (
        .clk(clk), .rst(rst),
        .a_in_valid(a_in_valid), .a_in_ready(a_in_ready), .a_in_addr(a_in_addr), .a_in_tag(a_in_tag),
        .a_out_valid(a_out_valid), .a_out_ready(a_out_ready), .a_out_data(a_out_data), .a_out_tag(a_out_tag),
        .b_in_valid(b_in_valid), .b_in_ready(b_in_ready), .b_in_addr(b_in_addr), .b_in_tag(b_in_tag),
        .b_out_valid(b_out_valid), .b_out_ready(b_out_ready), .b_out_data(b_out_data), .b_out_tag(b_out_tag),
        .rom_addra(rom_addra), .rom_addrb(rom_addrb), .rom_douta(rom_douta), .rom_doutb(rom_doutb)
    );

    function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) ^ 9'h155;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two-edge ROM: address sampled at edge N, data visible after edge N+1.
    always @(posedge clk) begin
        rom_a1    <= rom_f(rom_addra);
        rom_douta <= rom_a1;
        rom_b1    <= rom_f(rom_addrb);
        rom_doutb <= rom_b1;
    end

    // Scoreboard: sampled mid-cycle, when handshakes are stable for the next edge.
    always @(negedge clk) begin
        if (rst) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (a_in_valid && a_in_ready) q_a.push_back({rom_f(a_in_addr), a_in_tag});
            if (b_in_valid && b_in_ready) q_b.push_back({rom_f(b_in_addr), b_in_tag});
            if (a_out_valid && a_out_ready) begin
                resp_a++;
                n_checks++;
                if (q_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_a: unexpected response data=%h tag=%h, none outstanding", a_out_data, a_out_tag);
                end else begin
                    exp_a = q_a.pop_front();
                    if ({a_out_data, a_out_tag} !== exp_a) begin
                        n_fail++;
                        $display("FAIL sb_a: got data=%h tag=%h, expected data=%h tag=%h",
                                 a_out_data, a_out_tag, exp_a[DATA_W+TAG_W-1:TAG_W], exp_a[TAG_W-1:0]);
                    end
                end
            end
            if (b_out_valid && b_out_ready) begin
                resp_b++;
                n_checks++;
                if (q_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_b: unexpected response data=%h tag=%h, none outstanding", b_out_data, b_out_tag);
                end else begin
                    exp_b = q_b.pop_front();
                    if ({b_out_data, b_out_tag} !== exp_b) begin
                        n_fail++;
                        $display("FAIL sb_b: got data=%h tag=%h, expected data=%h tag=%h",
                                 b_out_data, b_out_tag, exp_b[DATA_W+TAG_W-1:TAG_W], exp_b[TAG_W-1:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        a_in_addr = '0; b_in_addr = '0; a_in_tag = '0; b_in_tag = '0;
        repeat (3) tick();
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_a_in_ready: got %b expected 0", a_in_ready); end
        n_checks++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_b_in_ready: got %b expected 0", b_in_ready); end
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_a_out_valid: got %b expected 0", a_out_valid); end
        n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_out_valid: got %b expected 0", b_out_valid); end
        rst = 1'b0;
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_a_in_ready: got %b expected 1", a_in_ready); end
        n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_b_in_ready: got %b expected 1", b_in_ready); end
        tick();
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_a_out_valid: got %b expected 0", a_out_valid); end
    endtask

    task automatic test_single();
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_addr = 12'h123; a_in_tag = 8'h05;
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", a_in_ready); end
        tick();
        a_in_valid = 1'b0;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat_n: got %b expected 0", a_out_valid); end
        tick();
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat_n1: got %b expected 0", a_out_valid); end
        tick();
        n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL single_lat_n2: got %b expected 1", a_out_valid); end
        n_checks++; if (a_out_data !== 9'h076) begin n_fail++; $display("FAIL single_data: got %h expected 076", a_out_data); end
        n_checks++; if (a_out_tag !== 8'h05) begin n_fail++; $display("FAIL single_tag: got %h expected 05", a_out_tag); end
        tick();
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got %b expected 0", a_out_valid); end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int last  = -1;
        int nv    = 0;
        int drops = 0;
        int r0    = resp_a;
        a_out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            a_in_valid = (c < 8);
            a_in_addr  = 12'(c);
            a_in_tag   = 8'(c);
            #1;
            if (c < 8 && !a_in_ready) drops++;
            tick();
            if (a_out_valid) begin
                if (first < 0) first = c;
                last = c;
                nv++;
            end
        end
        a_in_valid = 1'b0;
        n_checks++; if (drops !== 0) begin n_fail++; $display("FAIL b2b_ready_drops: got %0d expected 0", drops); end
        n_checks++; if (nv !== 8) begin n_fail++; $display("FAIL b2b_valid_cycles: got %0d expected 8", nv); end
        n_checks++; if (last - first !== 7) begin n_fail++; $display("FAIL b2b_consecutive: span %0d expected 7", last - first); end
        n_checks++; if (resp_a - r0 !== 8) begin n_fail++; $display("FAIL b2b_resp_count: got %0d expected 8", resp_a - r0); end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int r0  = resp_a;
        a_out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            a_in_valid = 1'b1;
            a_in_addr  = 12'h200 + 12'(idx);
            a_in_tag   = 8'h40 + 8'(idx);
            #1;
            if (a_in_ready) idx++;
            tick();
        end
        #1;
        n_checks++; if (idx !== 4) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 4", idx); end
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b expected 0", a_in_ready); end
        a_out_ready = 1'b1;
        for (int c = 0; c < 60 && (idx < 10 || a_out_valid); c++) begin
            a_in_valid = (idx < 10);
            a_in_addr  = 12'h200 + 12'(idx);
            a_in_tag   = 8'h40 + 8'(idx);
            #1;
            if (a_in_valid && a_in_ready) idx++;
            tick();
        end
        a_in_valid = 1'b0;
        repeat (6) tick();
        n_checks++; if (idx !== 10) begin n_fail++; $display("FAIL bp_total_accepted: got %0d expected 10", idx); end
        n_checks++; if (resp_a - r0 !== 10) begin n_fail++; $display("FAIL bp_resp_count: got %0d expected 10", resp_a - r0); end
    endtask

    task automatic test_dual_lanes();
        int ia = 0;
        int ib = 0;
        int a_drops = 0;
        int ra0 = resp_a;
        int rb0 = resp_b;
        a_out_ready = 1'b1;
        for (int c = 0; c < 100 && (ia < 12 || ib < 12); c++) begin
            a_in_valid  = (ia < 12);
            a_in_addr   = 12'h300 + 12'(ia);
            a_in_tag    = 8'h80 + 8'(ia);
            b_in_valid  = (ib < 12);
            b_in_addr   = 12'hF00 + 12'(ib * 37);
            b_in_tag    = 8'hC0 + 8'(ib);
            b_out_ready = (c % 2 == 0);
            #1;
            if (a_in_valid) begin
                if (a_in_ready) ia++;
                else a_drops++;
            end
            if (b_in_valid && b_in_ready) ib++;
            tick();
        end
        a_in_valid = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        repeat (10) tick();
        n_checks++; if (a_drops !== 0) begin n_fail++; $display("FAIL dual_a_full_rate: ready dropped %0d times, expected 0", a_drops); end
        n_checks++; if (ib !== 12) begin n_fail++; $display("FAIL dual_b_accepted: got %0d expected 12", ib); end
        n_checks++; if (resp_a - ra0 !== 12) begin n_fail++; $display("FAIL dual_a_resp: got %0d expected 12", resp_a - ra0); end
        n_checks++; if (resp_b - rb0 !== 12) begin n_fail++; $display("FAIL dual_b_resp: got %0d expected 12", resp_b - rb0); end
    endtask

    task automatic test_reset_flush();
        int stale = 0;
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_addr  = 12'h050 + 12'(i);
            a_in_tag   = 8'h10 + 8'(i);
            tick();
        end
        a_in_valid = 1'b0;
        n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_fifo_loaded: got %b expected 1", a_out_valid); end
        rst = 1'b1;
        #1;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_in_rst: got %b expected 0", a_out_valid); end
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready_in_rst: got %b expected 0", a_in_ready); end
        tick();
        rst = 1'b0;
        a_out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (a_out_valid !== 1'b0) stale++;
            tick();
        end
        n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL flush_stale_valid: got %0d cycles expected 0", stale); end
        a_in_valid = 1'b1; a_in_addr = 12'hABC; a_in_tag = 8'h3C;
        tick();
        a_in_valid = 1'b0;
        tick();
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_post_lat1: got %b expected 0", a_out_valid); end
        tick();
        n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_post_valid: got %b expected 1", a_out_valid); end
        n_checks++; if (a_out_data !== 9'h1E9) begin n_fail++; $display("FAIL flush_post_data: got %h expected 1e9", a_out_data); end
        n_checks++; if (a_out_tag !== 8'h3C) begin n_fail++; $display("FAIL flush_post_tag: got %h expected 3c", a_out_tag); end
        repeat (2) tick();
    endtask

    task automatic test_pop_not_credited();
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_addr  = 12'h7F0 + 12'(i);
            a_in_tag   = 8'hE0 + 8'(i);
            tick();
        end
        a_in_valid = 1'b0;
        repeat (2) tick();
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL credit_full_ready: got %b expected 0", a_in_ready); end
        a_out_ready = 1'b1;
        #1;
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL credit_pop_same_cycle: got %b expected 0", a_in_ready); end
        tick();
        a_out_ready = 1'b0;
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL credit_after_pop: got %b expected 1", a_in_ready); end
        a_out_ready = 1'b1;
        repeat (6) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_dual_lanes();
        test_reset_flush();
        test_pop_not_credited();
        repeat (4) tick();
        n_checks++; if (q_a.size() !== 0) begin n_fail++; $display("FAIL final_q_a: %0d outstanding, expected 0", q_a.size()); end
        n_checks++; if (q_b.size() !== 0) begin n_fail++; $display("FAIL final_q_b: %0d outstanding, expected 0", q_b.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
